wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back end of the MEM/WB interface: consumes the MEM/WB register outputs,
//  selects load data or ALU result, and commits it into a 32x32 register file.
//  Supplies ID-stage read ports with same-cycle write bypass, plus retire/load
//  counters for the pipeline bench. Sits after the MEM/WB register in the 5-stage core.
// PARAMETERS
//  DATA_W  32  register/data width
//  ADDR_W  5   register address width (2**ADDR_W registers)
//  CNT_W   32  width of retire_cnt and load_cnt
// PORTS
//  clk              in   1       clock, all state updates on rising edge
//  rst_n            in   1       asynchronous active-low reset
//  contral_out_b3   in   3       MEM/WB control: [2]=Reg_w, [1]=Mem_w, [0]=Mem_r
//  RdAddr_b3        in   ADDR_W  destination register
//  ALU_out_b2       in   DATA_W  ALU result from MEM/WB
//  mem_read_data_b  in   DATA_W  load data from MEM/WB
//  RsAddr           in   ADDR_W  ID-stage read address A
//  RtAddr           in   ADDR_W  ID-stage read address B
//  RsData           out  DATA_W  read data A (combinational)
//  RtData           out  DATA_W  read data B (combinational)
//  wb_en            out  1       write commits at next edge (combinational)
//  wb_data          out  DATA_W  selected write-back data (combinational)
//  retire_cnt       out  CNT_W   count of committed register writes
//  load_cnt         out  CNT_W   count of committed load writes
// BEHAVIOUR
//  - wb_data = Mem_r ? mem_read_data_b : ALU_out_b2 (Mem_r=bit0).
//  - wb_en = Reg_w & ~Mem_w & (RdAddr_b3 != 0). Mem_w=1 suppresses the write even
//    if Reg_w=1 (stores never write back); Reg_w=0 -> no write regardless of Mem_r.
//  - Commit: at rising clk with wb_en=1, regs[RdAddr_b3] <= wb_data. One-cycle
//    latency from MEM/WB outputs to register state.
//  - Register 0: never written, always reads 0, never bypassed.
//  - Reads: RsData = (RsAddr==0) ? 0 : (wb_en && RsAddr==RdAddr_b3) ? wb_data
//    : regs[RsAddr]; RtData identical with RtAddr. Bypass gives write-before-read
//    semantics in the same cycle; both ports may hit the bypass at once.
//  - Counters: retire_cnt += 1 on every edge with wb_en=1; load_cnt += 1 when
//    additionally Mem_r=1. Both wrap from 2**CNT_W-1 to 0, no saturation.
//  - Reset (rst_n=0, async, any time): all regs[1..] = 0, retire_cnt = 0,
//    load_cnt = 0 immediately; no commit on an edge while rst_n=0. Combinational
//    outputs follow inputs during reset (RsData/RtData bypass still active);
//    commit resumes on first rising edge with rst_n=1. Reset mid-write drops that write.
//  - X on contral_out_b3 must not corrupt state after reset: bench drives 0.
// TESTING
//  1 Reset: rst_n=0 mid-run -> all reads of r1..r31 = 0, retire_cnt=load_cnt=0
//    without waiting for clk; write presented during reset not committed.
//  2 ALU write: ctrl=3'b100, Rd=5, ALU=0x1234_5678 -> edge later RsAddr=5 reads
//    0x1234_5678, retire_cnt=1, load_cnt=0.
//  3 Load write + bypass: ctrl=3'b101, Rd=7, mem=0xDEAD_BEEF, ALU=0x1 with
//    RsAddr=RtAddr=7 same cycle -> both read 0xDEAD_BEEF before edge; after
//    edge reg7=0xDEAD_BEEF, load_cnt=1.
//  4 r0 protection: ctrl=3'b100, Rd=0, ALU=0xFFFF_FFFF -> RsAddr=0 reads 0 before
//    and after edge, wb_en=0, retire_cnt unchanged.
//  5 Suppressed writes: ctrl=3'b010 and 3'b110, Rd=9 -> reg9 unchanged, wb_en=0;
//    ctrl=3'b001 Rd=9 -> no write, load_cnt unchanged.
//  6 Back-to-back: writes to r3 on 32 consecutive cycles with ALU=cycle index ->
//    r3 ends at 31, retire_cnt=32; random 10k-cycle run vs. reference model.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage of the 5-stage core: selects load or ALU data from MEM/WB, commits it
// to a 32-entry register file, and serves the two ID-stage read ports with same-cycle bypass.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        contral_out_b3,
  input  logic [ADDR_W-1:0] RdAddr_b3,
  input  logic [DATA_W-1:0] ALU_out_b2,
  input  logic [DATA_W-1:0] mem_read_data_b,
  input  logic [ADDR_W-1:0] RsAddr,
  input  logic [ADDR_W-1:0] RtAddr,
  output logic [DATA_W-1:0] RsData,
  output logic [DATA_W-1:0] RtData,
  output logic              wb_en,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  load_cnt
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_r [0:NREGS-1];
  logic [CNT_W-1:0]  retire_cnt_r;
  logic [CNT_W-1:0]  load_cnt_r;
  logic              reg_w_s;
  logic              mem_w_s;
  logic              mem_r_s;
  logic              wb_en_s;
  logic [DATA_W-1:0] wb_data_s;
  logic [DATA_W-1:0] rs_data_s;
  logic [DATA_W-1:0] rt_data_s;

  assign reg_w_s = contral_out_b3[2];
  assign mem_w_s = contral_out_b3[1];
  assign mem_r_s = contral_out_b3[0];

  // Write-enable and write-data selection; stores and r0 targets never write back.
  always_comb begin
    wb_en_s   = 1'b0;
    wb_data_s = {DATA_W{1'b0}};
    if (reg_w_s && !mem_w_s && (RdAddr_b3 != {ADDR_W{1'b0}})) begin
      wb_en_s = 1'b1;
    end else begin
      wb_en_s = 1'b0;
    end
    if (mem_r_s) begin
      wb_data_s = mem_read_data_b;
    end else begin
      wb_data_s = ALU_out_b2;
    end
  end

  // Read ports: r0 hard-wired to zero, otherwise bypass the pending write before the array.
  always_comb begin
    rs_data_s = {DATA_W{1'b0}};
    rt_data_s = {DATA_W{1'b0}};
    if (RsAddr == {ADDR_W{1'b0}}) begin
      rs_data_s = {DATA_W{1'b0}};
    end else if (wb_en_s && (RsAddr == RdAddr_b3)) begin
      rs_data_s = wb_data_s;
    end else begin
      rs_data_s = regs_r[RsAddr];
    end
    if (RtAddr == {ADDR_W{1'b0}}) begin
      rt_data_s = {DATA_W{1'b0}};
    end else if (wb_en_s && (RtAddr == RdAddr_b3)) begin
      rt_data_s = wb_data_s;
    end else begin
      rt_data_s = regs_r[RtAddr];
    end
  end

  // Register array commit; entry 0 is cleared on reset and never targeted by wb_en_s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_en_s) begin
      regs_r[RdAddr_b3] <= wb_data_s;
    end
  end

  // Retire and load counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_r <= {CNT_W{1'b0}};
      load_cnt_r   <= {CNT_W{1'b0}};
    end else if (wb_en_s) begin
      retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (mem_r_s) begin
        load_cnt_r <= load_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign wb_en      = wb_en_s;
  assign wb_data    = wb_data_s;
  assign RsData     = rs_data_s;
  assign RtData     = rt_data_s;
  assign retire_cnt = retire_cnt_r;
  assign load_cnt   = load_cnt_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and reference-model bench for wb_regfile.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic [2:0]  contral_out_b3;
  logic [4:0]  RdAddr_b3;
  logic [31:0] ALU_out_b2;
  logic [31:0] mem_read_data_b;
  logic [4:0]  RsAddr;
  logic [4:0]  RtAddr;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [31:0] retire_cnt;
  logic [31:0] load_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_regs [0:31];
  logic [31:0] model_retire;
  logic [31:0] model_load;

  wb_regfile dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .contral_out_b3  (contral_out_b3),
    .RdAddr_b3       (RdAddr_b3),
    .ALU_out_b2      (ALU_out_b2),
    .mem_read_data_b (mem_read_data_b),
    .RsAddr          (RsAddr),
    .RtAddr          (RtAddr),
    .RsData          (RsData),
    .RtData          (RtData),
    .wb_en           (wb_en),
    .wb_data         (wb_data),
    .retire_cnt      (retire_cnt),
    .load_cnt        (load_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    contral_out_b3  = 3'b000;
    RdAddr_b3       = 5'd0;
    ALU_out_b2      = 32'h0;
    mem_read_data_b = 32'h0;
    RsAddr          = 5'd0;
    RtAddr          = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (retire_cnt !== 32'h0 || load_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnt: retire=%h load=%h expected 0/0", retire_cnt, load_cnt);
    end
    for (int a = 1; a < 32; a++) begin
      RsAddr = a[4:0];
      RtAddr = a[4:0];
      #1;
      checks++;
      if (RsData !== 32'h0 || RtData !== 32'h0) begin
        errors++;
        $display("FAIL reset_regs r%0d: rs=%h rt=%h expected 0", a, RsData, RtData);
      end
    end
  endtask

  task automatic test_alu_write();
    @(negedge clk);
    contral_out_b3 = 3'b100; RdAddr_b3 = 5'd5; ALU_out_b2 = 32'h1234_5678;
    mem_read_data_b = 32'h5555_AAAA; RsAddr = 5'd5; RtAddr = 5'd6;
    #1;
    checks++;
    if (wb_en !== 1'b1 || wb_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_sel: wb_en=%b wb_data=%h expected 1/12345678", wb_en, wb_data);
    end
    @(negedge clk);
    idle_inputs();
    RsAddr = 5'd5; RtAddr = 5'd6;
    #1;
    checks++;
    if (RsData !== 32'h1234_5678 || RtData !== 32'h0) begin
      errors++;
      $display("FAIL alu_commit: rs=%h rt=%h expected 12345678/0", RsData, RtData);
    end
    checks++;
    if (retire_cnt !== 32'd1 || load_cnt !== 32'd0) begin
      errors++;
      $display("FAIL alu_cnt: retire=%0d load=%0d expected 1/0", retire_cnt, load_cnt);
    end
  endtask

  task automatic test_load_bypass();
    @(negedge clk);
    contral_out_b3 = 3'b101; RdAddr_b3 = 5'd7; ALU_out_b2 = 32'h0000_0001;
    mem_read_data_b = 32'hDEAD_BEEF; RsAddr = 5'd7; RtAddr = 5'd7;
    #1;
    checks++;
    if (RsData !== 32'hDEAD_BEEF || RtData !== 32'hDEAD_BEEF || wb_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL load_bypass: rs=%h rt=%h wb_data=%h expected deadbeef", RsData, RtData, wb_data);
    end
    @(negedge clk);
    idle_inputs();
    RsAddr = 5'd7; RtAddr = 5'd5;
    #1;
    checks++;
    if (RsData !== 32'hDEAD_BEEF || RtData !== 32'h1234_5678) begin
      errors++;
      $display("FAIL load_commit: r7=%h r5=%h expected deadbeef/12345678", RsData, RtData);
    end
    checks++;
    if (retire_cnt !== 32'd2 || load_cnt !== 32'd1) begin
      errors++;
      $display("FAIL load_cnt: retire=%0d load=%0d expected 2/1", retire_cnt, load_cnt);
    end
  endtask

  task automatic test_r0_protect();
    @(negedge clk);
    contral_out_b3 = 3'b100; RdAddr_b3 = 5'd0; ALU_out_b2 = 32'hFFFF_FFFF;
    RsAddr = 5'd0; RtAddr = 5'd0;
    #1;
    checks++;
    if (RsData !== 32'h0 || RtData !== 32'h0 || wb_en !== 1'b0) begin
      errors++;
      $display("FAIL r0_pre: rs=%h rt=%h wb_en=%b expected 0/0/0", RsData, RtData, wb_en);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (RsData !== 32'h0 || retire_cnt !== 32'd2) begin
      errors++;
      $display("FAIL r0_post: rs=%h retire=%0d expected 0/2", RsData, retire_cnt);
    end
  endtask

  task automatic test_suppressed();
    logic [2:0] ctrl_tab [0:2];
    ctrl_tab[0] = 3'b010; ctrl_tab[1] = 3'b110; ctrl_tab[2] = 3'b001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      contral_out_b3 = ctrl_tab[k]; RdAddr_b3 = 5'd9;
      ALU_out_b2 = 32'hA5A5_0000 + k; mem_read_data_b = 32'h5A5A_0000 + k;
      RsAddr = 5'd9; RtAddr = 5'd9;
      #1;
      checks++;
      if (wb_en !== 1'b0 || RsData !== 32'h0) begin
        errors++;
        $display("FAIL suppress_pre ctrl=%b: wb_en=%b rs=%h expected 0/0", ctrl_tab[k], wb_en, RsData);
      end
      @(negedge clk);
      idle_inputs();
      RsAddr = 5'd9;
      #1;
      checks++;
      if (RsData !== 32'h0 || retire_cnt !== 32'd2 || load_cnt !== 32'd1) begin
        errors++;
        $display("FAIL suppress_post ctrl=%b: r9=%h retire=%0d load=%0d expected 0/2/1",
                 ctrl_tab[k], RsData, retire_cnt, load_cnt);
      end
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (retire_cnt !== 32'h0 || load_cnt !== 32'h0) begin
      errors++;
      $display("FAIL midreset_cnt: retire=%0d load=%0d expected 0/0", retire_cnt, load_cnt);
    end
    for (int a = 1; a < 32; a++) begin
      RsAddr = a[4:0];
      RtAddr = 5'd31 - a[4:0];
      #1;
      checks++;
      if (RsData !== 32'h0 || (RtAddr != 5'd0 && RtData !== 32'h0)) begin
        errors++;
        $display("FAIL midreset_regs r%0d: rs=%h rt=%h expected 0", a, RsData, RtData);
      end
    end
    @(negedge clk);
    contral_out_b3 = 3'b100; RdAddr_b3 = 5'd4; ALU_out_b2 = 32'hAAAA_5555;
    RsAddr = 5'd4; RtAddr = 5'd3;
    #1;
    checks++;
    if (RsData !== 32'hAAAA_5555 || RtData !== 32'h0) begin
      errors++;
      $display("FAIL midreset_bypass: rs=%h rt=%h expected aaaa5555/0", RsData, RtData);
    end
    @(negedge clk);
    contral_out_b3 = 3'b000;
    #1;
    checks++;
    if (RsData !== 32'h0 || retire_cnt !== 32'h0) begin
      errors++;
      $display("FAIL midreset_nocommit: r4=%h retire=%0d expected 0/0", RsData, retire_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      contral_out_b3 = 3'b100; RdAddr_b3 = 5'd3; ALU_out_b2 = i;
      RsAddr = 5'd3; RtAddr = 5'd0;
    end
    @(negedge clk);
    idle_inputs();
    RsAddr = 5'd3;
    #1;
    checks++;
    if (RsData !== 32'd31 || retire_cnt !== 32'd32 || load_cnt !== 32'd0) begin
      errors++;
      $display("FAIL b2b: r3=%0d retire=%0d load=%0d expected 31/32/0", RsData, retire_cnt, load_cnt);
    end
  endtask

  task automatic test_random();
    logic        exp_en;
    logic [31:0] exp_data;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    int          rand_errs;
    for (int r = 0; r < 32; r++) model_regs[r] = 32'h0;
    model_regs[3] = 32'd31;
    model_retire  = 32'd32;
    model_load    = 32'd0;
    rand_errs     = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      contral_out_b3  = $urandom_range(7, 0);
      RdAddr_b3       = $urandom_range(31, 0);
      ALU_out_b2      = $urandom;
      mem_read_data_b = $urandom;
      RsAddr          = (c % 4 == 0) ? RdAddr_b3 : 5'($urandom_range(31, 0));
      RtAddr          = (c % 5 == 0) ? RdAddr_b3 : 5'($urandom_range(31, 0));
      #1;
      exp_en   = contral_out_b3[2] && !contral_out_b3[1] && (RdAddr_b3 != 5'd0);
      exp_data = contral_out_b3[0] ? mem_read_data_b : ALU_out_b2;
      exp_rs   = (RsAddr == 5'd0) ? 32'h0 : (exp_en && RsAddr == RdAddr_b3) ? exp_data : model_regs[RsAddr];
      exp_rt   = (RtAddr == 5'd0) ? 32'h0 : (exp_en && RtAddr == RdAddr_b3) ? exp_data : model_regs[RtAddr];
      checks++;
      if (wb_en !== exp_en || wb_data !== exp_data || RsData !== exp_rs || RtData !== exp_rt ||
          retire_cnt !== model_retire || load_cnt !== model_load) begin
        errors++;
        rand_errs++;
        if (rand_errs <= 10)
          $display("FAIL random cyc %0d: en=%b/%b data=%h/%h rs=%h/%h rt=%h/%h ret=%0d/%0d ld=%0d/%0d (got/expected)",
                   c, wb_en, exp_en, wb_data, exp_data, RsData, exp_rs, RtData, exp_rt,
                   retire_cnt, model_retire, load_cnt, model_load);
      end
      @(posedge clk);
      if (exp_en) begin
        model_regs[RdAddr_b3] = exp_data;
        model_retire = model_retire + 32'd1;
        if (contral_out_b3[0]) model_load = model_load + 32'd1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load_bypass();
    test_r0_protect();
    test_suppressed();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
